// File: rtl/serial_chunk_adder.sv
// Multi-cycle ripple adder: CHUNK bits per clock, LS chunk first.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic             accept;
    logic             last;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK-1:0] s_c;
    logic [CHUNK:0]   c;

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign last = (idx_q == IW'(N - 1));

    assign a_c  = a_q[idx_q*CHUNK +: CHUNK];
    assign b_c  = b_q[idx_q*CHUNK +: CHUNK];
    assign c[0] = carry_q;

    // One full-adder cell per bit of the chunk.
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s_c[i]   = a_c[i] ^ b_c[i] ^ c[i];
        assign c[i+1]   = (a_c[i] & b_c[i]) | (c[i] & (a_c[i] ^ b_c[i]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (state_q == RUN) begin
            sum[idx_q*CHUNK +: CHUNK] <= s_c;
            carry_q <= c[CHUNK];
            idx_q   <= idx_q + IW'(1);
            if (last) begin
                cout <= c[CHUNK];
`ifdef SERIAL_ADDER_OVF_EN
                // c[CHUNK-1] is the carry into the MSB on the last chunk
                ovf  <= c[CHUNK] ^ c[CHUNK-1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed and random checks for serial_chunk_adder.
// Covers (16,4), (8,1) and (8,8) configurations.
module tb_serial_chunk_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout;
    logic [15:0] sum;

    logic        start1 = 1'b0;
    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        cin8 = 1'b0;
    logic        busy1, done1, cout1;
    logic        busy8, done8, cout8;
    logic [7:0]  sum1, sum8;

`ifdef SERIAL_ADDER_OVF_EN
    logic        ovf, ovf1, ovf8;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a(a8), .b(b8), .cin(cin8),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

    serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8),
        .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one add on the 16/4 DUT and check result and latency.
    task automatic add16(input string tag, input logic [15:0] av,
                         input logic [15:0] bv, input logic cv,
                         input logic [16:0] exp);
        int lat;
        @(negedge clk);
        a = av; b = bv; cin = cv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_sum"}, {15'd0, cout, sum}, {15'd0, exp});
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"}, {31'd0, ovf},
            {31'd0, (av[15] == bv[15]) && (exp[15] != av[15])});
`endif
    endtask

    task automatic add8(input bit one, input logic [7:0] av,
                        input logic [7:0] bv, input logic cv);
        int         lat;
        logic [8:0] e;
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = cv;
        if (one) start1 = 1'b1;
        else start8 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start8 = 1'b0;
        lat = 0;
        while (!(one ? done1 : done8) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        e = 9'(av) + 9'(bv) + 9'(cv);
        chk(one ? "lat8x1" : "lat8x8", lat, one ? 8 : 1);
        chk(one ? "sum8x1" : "sum8x8",
            {23'd0, one ? {cout1, sum1} : {cout8, sum8}}, {23'd0, e});
`ifdef SERIAL_ADDER_OVF_EN
        chk(one ? "ovf8x1" : "ovf8x8", {31'd0, one ? ovf1 : ovf8},
            {31'd0, (av[7] == bv[7]) && (e[7] != av[7])});
`endif
    endtask

    initial begin
        int         n;
        int         nd;
        logic [15:0] ra, rb;
        logic        rc;
        logic [7:0]  qa, qb;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_sum", {15'd0, cout, sum}, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", {31'd0, ovf}, 0);
`endif
        rst_n = 1'b1;

        // Basic add with cycle-by-cycle busy/done profile
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("busy_%0d", j), {31'd0, busy}, {31'd0, j < 4});
            chk($sformatf("done_%0d", j), {31'd0, done}, {31'd0, j == 4});
            if (j < 5) @(negedge clk);
        end
        chk("basic_sum", {15'd0, cout, sum}, 32'h0100);

        add16("ripple", 16'hFFFF, 16'h0000, 1'b1, 17'h10000);
        add16("sovf", 16'h7FFF, 16'h0001, 1'b0, 17'h08000);

        // Start while busy is ignored
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int j = 0; j < 8; j++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("busy_start_done_cnt", nd, 1);
        chk("busy_start_sum", {15'd0, cout, sum}, 32'h0100);
        chk("busy_start_idle", {31'd0, busy}, 0);

        // Back-to-back: start held through DONE
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_sum", {15'd0, cout, sum}, 32'h0003);
        a = 16'h1000; b = 16'h2000; cin = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            start = 1'b0;
        end while (!done && n < 20);
        chk("b2b_gap", n, 5);
        chk("b2b_second_sum", {15'd0, cout, sum}, 32'h3001);

        // Reset in the middle of an add
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 1);
        chk("mid_partial", {16'd0, sum}, 32'h0003);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_done", {31'd0, done}, 0);
        chk("arst_sum", {15'd0, cout, sum}, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("arst_ovf", {31'd0, ovf}, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int j = 0; j < 8; j++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("arst_no_done", nd, 0);
        add16("after_rst", 16'h1234, 16'h4321, 1'b1, 17'h05556);

        // Random sweeps over the three configurations
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            add16("rnd16", ra, rb, rc, 17'(ra) + 17'(rb) + 17'(rc));
        end
        add8(1'b1, 8'hFF, 8'hFF, 1'b1);
        add8(1'b0, 8'hFF, 8'hFF, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            qa = 8'($urandom);
            qb = 8'($urandom);
            add8(1'b1, qa, qb, 1'($urandom));
            qa = 8'($urandom);
            qb = 8'($urandom);
            add8(1'b0, qa, qb, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
